// File: rtl/core_boot_loader.sv
// core_boot_loader: receives a length-prefixed byte stream, writes 9-bit words to instruction memory,
// and keeps the core in reset until the whole program has been loaded.
module core_boot_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [7:0]            i_data,
   output logic                  o_ready,
   input  logic                  i_restart,
   output logic                  o_core_rst,
   output logic                  o_imem_we,
   output logic [ADDR_WIDTH-1:0] o_imem_addr,
   output logic [8:0]            o_imem_data,
   output logic                  o_done,
   output logic                  o_error
);
   localparam logic [2:0] LEN_LO = 3'd0, LEN_HI = 3'd1, DAT_LO = 3'd2, DAT_HI = 3'd3,
                          RUN = 3'd4, ERR = 3'd5;
   localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);
   logic [2:0]          state;
   logic                armed;
   logic [7:0]          len_lo, dat_lo;
   logic [ADDR_WIDTH:0] len, cnt, cnt_nx;
   logic [16:0]         len_in;
   logic                xfer;
   // armed holds o_ready low until the first clock after reset release
   assign o_ready    = armed && (state < RUN) && !o_imem_we;
   assign xfer       = i_valid && o_ready && !i_restart;
   assign cnt_nx     = cnt + 1'b1;
   assign len_in     = {1'b0, i_data, len_lo};
   assign o_core_rst = state != RUN;
   assign o_done     = state == RUN;
   assign o_error    = state == ERR;
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state       <= LEN_LO;
         armed       <= 1'b0;
         len_lo      <= '0;
         dat_lo      <= '0;
         len         <= '0;
         cnt         <= '0;
         o_imem_we   <= 1'b0;
         o_imem_addr <= '0;
         o_imem_data <= '0;
      end else begin
         armed     <= 1'b1;
         o_imem_we <= 1'b0;
         if (i_restart) begin
            state <= LEN_LO;
            cnt   <= '0;
         end else if (o_imem_we) begin
            // the write cycle completes the word; the counter is wide enough to reach 2**ADDR_WIDTH
            cnt   <= cnt_nx;
            state <= (cnt_nx == len) ? RUN : DAT_LO;
         end else if (xfer) begin
            case (state)
               LEN_LO: begin
                  len_lo <= i_data;
                  state  <= LEN_HI;
               end
               LEN_HI: begin
                  len   <= len_in[ADDR_WIDTH:0];
                  cnt   <= '0;
                  state <= (len_in == 17'd0 || len_in > MAX_LEN) ? ERR : DAT_LO;
               end
               DAT_LO: begin
                  dat_lo <= i_data;
                  state  <= DAT_HI;
               end
               DAT_HI: begin
                  o_imem_we   <= 1'b1;
                  o_imem_addr <= cnt[ADDR_WIDTH-1:0];
                  o_imem_data <= {i_data[0], dat_lo};
               end
               default: ;
            endcase
         end
      end
   end
endmodule
